cmd_tx: RTL

CMD_TX -- requirements
Module: cmd_tx

---
 rtl/cmd_tx_if.sv | 31 +++
 rtl/cmd_tx.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cmd_tx_if.sv
// Byte stream in, verified command and error status out.
// The master drives receive bytes; the slave (cmd_tx) drives results.
interface cmd_tx_if;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        cmdvalid;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        frame_err;
    logic [15:0] err_cnt;

    modport master (
        output rx_byte,
        output rx_valid,
        input  cmdvalid,
        input  cmd_addr,
        input  cmd_data,
        input  frame_err,
        input  err_cnt
    );

    modport slave (
        input  rx_byte,
        input  rx_valid,
        output cmdvalid,
        output cmd_addr,
        output cmd_data,
        output frame_err,
        output err_cnt
    );
endinterface

// File: rtl/cmd_tx.sv
// Command frame decoder: 55 AA ADDR D3..D0 CSUM with inter-byte timeout.
// Commits addr/data only after the checksum byte matches.
module cmd_tx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic     clk,
    input  logic     reset_n,
    cmd_tx_if.slave  bus
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR2,
        ADDR,
        DATA,
        CSUM
    } state_t;

    state_t          state, state_n;
    logic [7:0]      sh_addr, sh_addr_n;
    logic [31:0]     sh_data, sh_data_n;
    logic [1:0]      byte_cnt, byte_cnt_n;
    logic [7:0]      csum, csum_n;
    logic [TO_W-1:0] to_cnt, to_cnt_n;
    logic [7:0]      cmd_addr, cmd_addr_n;
    logic [31:0]     cmd_data, cmd_data_n;
    logic            cmdvalid, cmdvalid_n;
    logic            frame_err, frame_err_n;
    logic [15:0]     err_cnt, err_cnt_n;
    logic            timeout;

    // Fires on the idle cycle that would bring the gap to TIMEOUT_CYCLES
    assign timeout = (state != IDLE) && !bus.rx_valid &&
                     (to_cnt == TO_LAST);

    always_comb begin
        state_n     = state;
        sh_addr_n   = sh_addr;
        sh_data_n   = sh_data;
        byte_cnt_n  = byte_cnt;
        csum_n      = csum;
        cmd_addr_n  = cmd_addr;
        cmd_data_n  = cmd_data;
        cmdvalid_n  = 1'b0;
        frame_err_n = 1'b0;
        err_cnt_n   = err_cnt;

        if (timeout) begin
            state_n     = IDLE;
            frame_err_n = 1'b1;
        end else if (bus.rx_valid) begin
            unique case (state)
                IDLE: begin
                    if (bus.rx_byte == 8'h55)
                        state_n = HDR2;
                end
                HDR2: begin
                    if (bus.rx_byte == 8'hAA)
                        state_n = ADDR;
                    else if (bus.rx_byte != 8'h55)
                        state_n = IDLE;
                end
                ADDR: begin
                    sh_addr_n  = bus.rx_byte;
                    csum_n     = bus.rx_byte;
                    byte_cnt_n = 2'd0;
                    state_n    = DATA;
                end
                DATA: begin
                    sh_data_n  = {sh_data[23:0], bus.rx_byte};
                    csum_n     = csum + bus.rx_byte;
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3)
                        state_n = CSUM;
                end
                CSUM: begin
                    if (bus.rx_byte == csum) begin
                        cmd_addr_n = sh_addr;
                        cmd_data_n = sh_data;
                        cmdvalid_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end

        if (frame_err_n && (err_cnt != 16'hFFFF))
            err_cnt_n = err_cnt + 16'd1;
    end

    always_comb begin
        if ((state == IDLE) || bus.rx_valid || timeout)
            to_cnt_n = '0;
        else
            to_cnt_n = to_cnt + TO_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sh_addr   <= '0;
            sh_data   <= '0;
            byte_cnt  <= '0;
            csum      <= '0;
            to_cnt    <= '0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            cmdvalid  <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_n;
            sh_addr   <= sh_addr_n;
            sh_data   <= sh_data_n;
            byte_cnt  <= byte_cnt_n;
            csum      <= csum_n;
            to_cnt    <= to_cnt_n;
            cmd_addr  <= cmd_addr_n;
            cmd_data  <= cmd_data_n;
            cmdvalid  <= cmdvalid_n;
            frame_err <= frame_err_n;
            err_cnt   <= err_cnt_n;
        end
    end

    assign bus.cmdvalid  = cmdvalid;
    assign bus.cmd_addr  = cmd_addr;
    assign bus.cmd_data  = cmd_data;
    assign bus.frame_err = frame_err;
    assign bus.err_cnt   = err_cnt;

endmodule
